// File: rtl/sysbus_pkg.sv
// System bus definitions shared by the line bus controller, its beat
// shifter and its bench: tag field layout, tag type and device codes,
// and the controller state encoding.
package sysbus_pkg;

    // Tag layout: {type, device[3:0], id[7:0]}
    localparam int TAG_ID_LSB   = 0;
    localparam int TAG_ID_W     = 8;
    localparam int TAG_DEV_LSB  = 8;
    localparam int TAG_DEV_W    = 4;
    localparam int TAG_TYPE_LSB = 12;
    localparam int TAG_W        = 13;

    // The type field is a single bit. Writes never get a response, so on
    // the response channel the write code is reused to mark an invalidate.
    localparam logic READ       = 1'b1;
    localparam logic WRITE      = 1'b0;
    localparam logic INVALIDATE = 1'b0;

    localparam logic [TAG_DEV_W-1:0] MEMORY = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RWAIT,
        RECV,
        DONE
    } ctrl_state_t;

    function automatic logic [TAG_W-1:0] make_tag(input logic kind, input logic [TAG_ID_W-1:0] id);
        return {kind, MEMORY, id};
    endfunction

endpackage

// File: rtl/line_bus_controller_if.sv
// System bus port bundle. The controller side drives the request channel
// and the response acknowledge; the memory side drives the rest.
interface line_bus_controller_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/line_beat_shifter.sv
// Line buffer addressed by beat index: presents the selected beat for
// write bursts and merges incoming beats for read bursts.
module line_beat_shifter #(
    parameter int W      = 64,
    parameter int BEATS  = 8,
    parameter int BEAT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [W*BEATS-1:0]   load_line,
    input  logic                 store,
    input  logic [BEAT_W-1:0]    beat,
    input  logic [W-1:0]         store_word,
    output logic [W-1:0]         beat_word,
    output logic [W*BEATS-1:0]   line_next
);
    logic [W*BEATS-1:0] line_q;

    // Select the current beat and merge a stored beat into the line
    always_comb begin
        beat_word = line_q[int'(beat)*W +: W];
        line_next = line_q;
        if (store) begin
            line_next[int'(beat)*W +: W] = store_word;
        end
    end

    // Line register: a whole-line load wins over a beat store
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else begin
            line_q <= line_next;
        end
    end
endmodule

// File: rtl/line_bus_controller.sv
// Moves one cache line per transaction between the cache arbiter and the
// system bus as an address beat followed by a data burst. Each transaction
// carries a rolling 8-bit id in the bus tag.
// Optional: MEMCTL_INVALIDATE_EN forwards bus invalidations to the cache.
module line_bus_controller
    import sysbus_pkg::*;
#(
    parameter  int BUS_DATA_WIDTH = 64,
    parameter  int BUS_TAG_WIDTH  = 13,
    parameter  int LINE_BYTES     = 64,
    parameter  int ADDR_WIDTH     = 64,
    localparam int LINE_W         = LINE_BYTES * 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [LINE_W-1:0]       req_data,
    output logic                    resp_valid,
    output logic [LINE_W-1:0]       resp_data,
    output logic                    inv_valid,
    output logic [ADDR_WIDTH-1:0]   inv_addr,
    line_bus_controller_if.master   bus
);
    localparam int BEATS  = LINE_W / BUS_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

    ctrl_state_t           state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [TAG_ID_W-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [LINE_W-1:0]     resp_data_q;

    logic                      latch, store, capture, rd_hit, inv_ack;
    logic                      reqcyc, respack;
    logic [BUS_DATA_WIDTH-1:0] req_word, beat_word;
    logic [BUS_TAG_WIDTH-1:0]  req_tag;
    logic [LINE_W-1:0]         line_next;
    logic                      unused_tag_dev;

    assign unused_tag_dev = ^bus.bus_resptag[TAG_DEV_LSB +: TAG_DEV_W];

    assign rd_hit = bus.bus_respcyc
                 && (bus.bus_resptag[TAG_TYPE_LSB] == READ)
                 && (bus.bus_resptag[TAG_ID_LSB +: TAG_ID_W] == id_q);

    line_beat_shifter #(
        .W      (BUS_DATA_WIDTH),
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (latch),
        .load_line  (req_data),
        .store      (store),
        .beat       (beat_q),
        .store_word (bus.bus_resp),
        .beat_word  (beat_word),
        .line_next  (line_next)
    );

`ifdef MEMCTL_INVALIDATE_EN
    logic                  inv_valid_q;
    logic [ADDR_WIDTH-1:0] inv_addr_q;

    // Invalidates are taken everywhere except mid read burst and DONE
    assign inv_ack = !rst && bus.bus_respcyc
                  && (bus.bus_resptag[TAG_TYPE_LSB] == INVALIDATE)
                  && (state_q != RECV) && (state_q != DONE);

    // Forward an acked invalidate to the cache one cycle later, line aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_valid_q <= 1'b0;
            inv_addr_q  <= '0;
        end else begin
            inv_valid_q <= inv_ack;
            if (inv_ack) begin
                inv_addr_q <= bus.bus_resp[ADDR_WIDTH-1:0] & ALIGN_MASK;
            end
        end
    end

    assign inv_valid = inv_valid_q;
    assign inv_addr  = inv_addr_q;
`else
    assign inv_ack   = 1'b0;
    assign inv_valid = 1'b0;
    assign inv_addr  = '0;
`endif

    // Next-state and bus outputs; reset forces every strobe low at once
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        latch      = 1'b0;
        store      = 1'b0;
        capture    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        reqcyc     = 1'b0;
        respack    = 1'b0;
        req_word   = '0;
        req_tag    = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    latch   = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                reqcyc   = 1'b1;
                req_word = BUS_DATA_WIDTH'(addr_q);
                req_tag  = BUS_TAG_WIDTH'(make_tag(wr_q ? WRITE : READ, id_q));
                if (bus.bus_reqack) begin
                    beat_d  = '0;
                    state_d = wr_q ? WDATA : RWAIT;
                end
            end
            WDATA: begin
                reqcyc   = 1'b1;
                req_word = beat_word;
                req_tag  = BUS_TAG_WIDTH'(make_tag(WRITE, id_q));
                if (bus.bus_reqack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RWAIT, RECV: begin
                if (rd_hit) begin
                    respack = 1'b1;
                    store   = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        capture = 1'b1;
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = RECV;
                    end
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (inv_ack) begin
            respack = 1'b1;
        end
        if (rst) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            reqcyc     = 1'b0;
            respack    = 1'b0;
            req_word   = '0;
            req_tag    = '0;
        end
    end

    // State, beat index, rolling id and latched request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            id_q        <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (latch) begin
                addr_q <= req_addr & ALIGN_MASK;
                wr_q   <= req_wr;
            end
            if (capture) begin
                resp_data_q <= line_next;
            end
            if (state_q == DONE) begin
                id_q <= id_q + 1'b1;
            end
        end
    end

    assign resp_data       = resp_data_q;
    assign bus.bus_reqcyc  = reqcyc;
    assign bus.bus_req     = req_word;
    assign bus.bus_reqtag  = req_tag;
    assign bus.bus_respack = respack;
endmodule

// File: doc/line_bus_controller.md
Name: line_bus_controller

Overview:
- Parametrised successor to the single-line memory controller: moves one cache line per transaction between the cache arbiter and the system bus.
- Does beat-by-beat read bursts and write bursts over a configurable bus width and line size.
- Uses a proper valid/ready request interface, a rolling transaction id in the bus tag, and optional forwarding of bus invalidations to the cache.
- Sits between the cache arbiter and the top-level bus ports.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp in bits.
- BUS_TAG_WIDTH, 13, tag width: {type[0], device[3:0], id[7:0]} in the 13-bit layout.
- LINE_BYTES, 64, cache line size in bytes; LINE_BYTES*8 must be a multiple of BUS_DATA_WIDTH.
- ADDR_WIDTH, 64, request address width. It must be ≤ BUS_DATA_WIDTH because the address travels on bus_req.
- Derived: LINE_W = LINE_BYTES*8; BEATS = LINE_W/BUS_DATA_WIDTH (default 8); OFS = log2(LINE_BYTES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  arbiter request valid
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = write line, 0 = read line
- req_addr  in  ADDR_WIDTH  byte address
- req_data  in  LINE_W  write line data
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  LINE_W  read line; holds its last value after writes
- inv_valid  out  1  invalidate pulse (feature only)
- inv_addr  out  ADDR_WIDTH  line address to invalidate
- bus_reqcyc  out  1
- bus_reqack  in  1
- bus_req  out  BUS_DATA_WIDTH
- bus_reqtag  out  BUS_TAG_WIDTH
- bus_respcyc  in  1
- bus_respack  out  1
- bus_resp  in  BUS_DATA_WIDTH
- bus_resptag  in  BUS_TAG_WIDTH

Behaviour:
- States:
  - IDLE: req_ready=1. On req_valid, latch addr (low OFS bits cleared), wr, data; go to ADDR.
  - ADDR: bus_reqcyc=1, bus_req=aligned addr, bus_reqtag={wr?WRITE:READ, MEMORY, id}. Hold until bus_reqack.
    - On ack with wr=1: go to WDATA, beat=0.
    - On ack with wr=0: go to RWAIT.
  - WDATA: bus_reqcyc=1, bus_req=line[beat*W +: W], tag as in ADDR. Each cycle with bus_reqack, beat++. On the ack of beat BEATS-1, go to DONE.
  - RWAIT/RECV: a beat is accepted when bus_respcyc=1, resptag type=READ and resptag id=current id.
    - On acceptance, bus_respack=1 combinationally in the same cycle and bus_resp is stored into line[beat*W +: W].
    - Beats are in order; beat 0 moves RWAIT→RECV. The last beat moves RECV→DONE.
    - Gaps (respcyc=0) inside a burst are legal; beat holds.
  - DONE: one cycle. resp_valid=1, resp_data=line, id++ (wraps 8'hFF→8'h00). Go to IDLE.
- Latency:
  - Request accepted at cycle 0; bus_reqcyc rises at cycle 1.
  - Read: resp_valid rises the cycle after the last beat.
  - Minimum write: 1+1+BEATS+1 cycles with ack tied high.
- bus_reqcyc is never high outside ADDR/WDATA. bus_req and bus_reqtag are 0 when bus_reqcyc=0.
- Responses that are not accepted are not acked; the feature below is the only exception.
- req_valid while not IDLE is ignored (req_ready=0).
- Reset values: all outputs 0, state IDLE, id 0, beat 0, line 0.
- Reset mid-burst: abort immediately. No resp_valid is emitted; bus_reqcyc/bus_respack are 0 from the reset cycle.

Optional Feature:
- MEMCTL_INVALIDATE_EN defined:
  - In IDLE, ADDR, WDATA or RWAIT, a bus_respcyc with resptag type=INVALIDATE is acked the same cycle.
  - Next cycle: inv_valid=1 for one cycle, inv_addr=bus_resp[ADDR_WIDTH-1:0] with low OFS bits cleared.
  - In RECV, invalidates are not acked; the bus retries them.
  - The current transaction is unaffected.
- Undefined: inv_valid/inv_addr tied 0 and INVALIDATE tags are never acked.

Decomposition:
- Package sysbus_pkg holds:
  - tag type constants READ, WRITE, INVALIDATE; device constant MEMORY;
  - tag field offsets;
  - state enum typedef.
- Natural sub-module: line_beat_shifter, which serialises the write line and assembles the read line via beat index.

Test Plan:
- Read at addr 0x1234 with bus_reqack after 2 cycles, then 8 beats 0x11..0x88 → bus_req=0x1200, tag={READ,MEMORY,0x00}; resp_data[63:0]=0x11, [511:448]=0x88; resp_valid one cycle; next tag id=0x01.
- Write at 0x4000 with data beats 0xA0..0xA7, reqack toggling 1/0 → beats appear in order, each held until acked; resp_valid after 8th ack; bus_reqcyc 0 afterwards.
- Read burst with respcyc gaps, plus one beat with wrong id 0x05 → gaps tolerated; wrong-id beat not acked and not stored; line correct.
- Reset asserted during beat 3 of a write → next cycle all outputs 0, req_ready=1, no resp_valid.
- 256 back-to-back reads → id wraps 0xFF→0x00 correctly.
- MEMCTL_INVALIDATE_EN: INVALIDATE with bus_resp=0x8047 in IDLE → respack same cycle; inv_valid next cycle with inv_addr=0x8040. Repeated during RECV → not acked.
